// File: rtl/dmc_pkg.sv
// Shared types and constants for the data-memory controller.
package dmc_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_BUS  = 2'd1,
    S_RD_BUS  = 2'd2,
    S_RD_DONE = 2'd3
  } dmc_state_t;

  localparam logic [31:0] READ_ERR_DATA = 32'h0000_0000;
  localparam logic [1:0]  ALIGN_MASK    = 2'b11;

endpackage

// File: rtl/M__TimeoutCounter.sv
// Loadable up-counter with clear and a terminal-count flag at TERM.
module M__TimeoutCounter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TERM  = '1
) (
  input  logic             clock__i,
  input  logic             reset_n__i,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clock__i) begin
    if (!reset_n__i)  r_cnt <= '0;
    else if (i_clr)   r_cnt <= '0;
    else if (i_load)  r_cnt <= i_load_val;
    else if (i_en)    r_cnt <= r_cnt + WIDTH'(1);
  end

  assign o_tc = (r_cnt == TERM);

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: strobes to req/ack bus, stalling reads,
// one-entry posted write buffer, misalign/both-strobe and timeout errors.
module data_mem_ctrl
  import dmc_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock__i,
  input  logic                  reset_n__i,
  input  logic [ADDR_WIDTH-1:0] memAddr__i,
  input  logic [DATA_WIDTH-1:0] memDataWrite__i,
  input  logic                  memRead__i,
  input  logic                  memWrite__i,
  output logic [DATA_WIDTH-1:0] memDataRead__o,
  output logic                  memStall__o,
  output logic                  memError__o,
  output logic                  busReq__o,
  output logic                  busWe__o,
  output logic [ADDR_WIDTH-1:0] busAddr__o,
  output logic [DATA_WIDTH-1:0] busWData__o,
  input  logic                  busAck__i,
  input  logic [DATA_WIDTH-1:0] busRData__i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  dmc_state_t            r_state;
  logic                  r_req, r_we, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;

  logic w_misalign, w_idle, w_in_bus, w_rd_acc, w_wr_acc, w_bad;
  logic w_ack, w_tc, w_tmo, w_stall;

  assign w_misalign = |(memAddr__i[1:0] & ALIGN_MASK);
  assign w_idle     = (r_state == S_IDLE);
  assign w_in_bus   = (r_state == S_RD_BUS) || (r_state == S_WR_BUS);
  assign w_rd_acc   = w_idle & memRead__i & ~memWrite__i & ~w_misalign;
  assign w_wr_acc   = w_idle & memWrite__i & ~memRead__i & ~w_misalign;
  assign w_bad      = w_idle & (memRead__i | memWrite__i) &
                      (w_misalign | (memRead__i & memWrite__i));
  // Ack wins over timeout when both land in the same cycle.
  assign w_ack      = w_in_bus & busAck__i;
  assign w_tmo      = w_in_bus & ~busAck__i & w_tc;

  M__TimeoutCounter #(
    .WIDTH (CNT_W),
    .TERM  (CNT_W'(TIMEOUT_CYCLES))
  ) u_tmo_cnt (
    .clock__i   (clock__i),
    .reset_n__i (reset_n__i),
    .i_clr      (w_ack | w_tmo),
    .i_load     (w_rd_acc | w_wr_acc),
    .i_load_val (CNT_W'(1)),
    .i_en       (w_in_bus),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clock__i) begin
    if (!reset_n__i) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_bad | w_tmo;
      case (r_state)
        S_IDLE: begin
          if (w_rd_acc) begin
            r_state <= S_RD_BUS;
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= {memAddr__i[ADDR_WIDTH-1:2], 2'b00};
          end else if (w_wr_acc) begin
            r_state <= S_WR_BUS;
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= {memAddr__i[ADDR_WIDTH-1:2], 2'b00};
            r_wdata <= memDataWrite__i;
          end
        end
        S_RD_BUS: begin
          if (w_ack || w_tmo) begin
            r_state <= S_RD_DONE;
            r_req   <= 1'b0;
            r_rdata <= w_ack ? busRData__i : DATA_WIDTH'(READ_ERR_DATA);
          end
        end
        S_WR_BUS: begin
          if (w_ack || w_tmo) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        S_RD_DONE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Posted writes never stall on acceptance; anything arriving while the
  // buffer drains waits for IDLE.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:   w_stall = w_rd_acc;
      S_RD_BUS: w_stall = 1'b1;
      S_WR_BUS: w_stall = memRead__i | memWrite__i;
      default:  w_stall = 1'b0;
    endcase
  end

  assign memStall__o    = w_stall;
  assign memDataRead__o = r_rdata;
  assign memError__o    = r_err;
  assign busReq__o      = r_req;
  assign busWe__o       = r_we;
  assign busAddr__o     = r_addr;
  assign busWData__o    = r_wdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed cases plus random traffic against a
// transaction-level latency/data model and a bus slave with programmable ack delay.
module tb_data_mem_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] mem_addr = '0, mem_wd = '0, mem_rdata;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic        stall, err, breq, bwe, back = 1'b0;
  logic [31:0] baddr, bwdata, brdata = '0;

  data_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clock__i        (clk),
    .reset_n__i      (rst_n),
    .memAddr__i      (mem_addr),
    .memDataWrite__i (mem_wd),
    .memRead__i      (mem_rd),
    .memWrite__i     (mem_wr),
    .memDataRead__o  (mem_rdata),
    .memStall__o     (stall),
    .memError__o     (err),
    .busReq__o       (breq),
    .busWe__o        (bwe),
    .busAddr__o      (baddr),
    .busWData__o     (bwdata),
    .busAck__i       (back),
    .busRData__i     (brdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int req_cyc = 0, err_cyc = 0;
  int exp_req = 0, exp_err = 0, busy = 0;
  int dly_q[$];
  int cur_dly = 0, rcnt = 0;
  logic req_q = 1'b0, force_ack = 1'b0;
  logic [31:0] lat_addr = '0;
  logic [31:0] bus_mem [64];
  logic [31:0] ref_mem [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    req_cyc += int'(breq);
    err_cyc += int'(err);
  end

  // Advance one clock; the bus slave then answers for the new cycle.
  task automatic cyc();
    @(posedge clk); #1;
    back = 1'b0;
    if (breq === 1'b1) begin
      if (req_q !== 1'b1) begin
        cur_dly  = (dly_q.size() > 0) ? dly_q.pop_front() : 1000;
        rcnt     = 0;
        lat_addr = baddr;
      end else chk("baddr_stable", baddr, lat_addr);
      if (rcnt == cur_dly) begin
        back = 1'b1;
        if (bwe) bus_mem[baddr[7:2]] = bwdata;
        else     brdata = bus_mem[baddr[7:2]];
      end
      rcnt++;
    end else rcnt = 0;
    if (force_ack) back = 1'b1;
    req_q = breq;
  endtask

  // kind: 0 read, 1 write, 2 both strobes. Misalignment comes from a[1:0].
  task automatic core_op(input int kind, input logic [31:0] a, input logic [31:0] wd,
                         input int dly, input int gap);
    int extra, w, n, exp_st;
    bit bad, ok;
    logic [31:0] exp_d;
    exp_d = '0;
    repeat (gap) begin cyc(); mem_rd = 1'b0; mem_wr = 1'b0; end
    cyc();
    mem_addr = a; mem_wd = wd;
    mem_rd = (kind != 1); mem_wr = (kind != 0);
    bad   = (a[1:0] != 2'b00) || (kind == 2);
    extra = (busy > gap) ? busy - gap : 0;
    ok    = (dly + 1 <= T);
    w     = ok ? dly + 1 : T;
    busy  = 0;
    if (bad) begin
      exp_st = extra;
      exp_err++;
    end else begin
      dly_q.push_back(dly);
      exp_req += w;
      if (!ok) exp_err++;
      if (kind == 0) begin
        exp_st = extra + (ok ? dly + 2 : T + 1);
        exp_d  = ok ? ref_mem[a[7:2]] : 32'h0;
      end else begin
        exp_st = extra;
        busy   = w;
        if (ok) ref_mem[a[7:2]] = wd;
      end
    end
    n = 0;
    @(negedge clk);
    while (stall && n < 200) begin n++; cyc(); @(negedge clk); end
    chk("stall_cycles", n, exp_st);
    if (!bad && kind == 0) chk("rdata", mem_rdata, exp_d);
  endtask

  initial begin
    int r0, e0, r1;
    logic [5:0] idx;
    for (int i = 0; i < 64; i++) begin
      bus_mem[i] = $urandom;
      ref_mem[i] = bus_mem[i];
    end

    // Reset values
    cyc(); cyc();
    @(negedge clk);
    chk("rst_busReq", breq, 0);
    chk("rst_busWe", bwe, 0);
    chk("rst_busAddr", baddr, 0);
    chk("rst_busWData", bwdata, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    cyc(); rst_n = 1'b1;

    // Read with ack in first request cycle
    bus_mem[4] = 32'h1234_5678; ref_mem[4] = 32'h1234_5678;
    r1 = req_cyc;
    core_op(0, 32'h10, 32'h0, 0, 0);
    chk("rd0_breq_low", breq, 0);
    chk("rd0_req_cycles", req_cyc - r1, 1);

    // Posted write then read of the same word, ack delayed 4 cycles each
    core_op(1, 32'h20, 32'hCAFE_F00D, 4, 0);
    core_op(0, 32'h20, 32'h0, 4, 0);

    // Reset during RD_BUS, then late ack, then a normal read
    cyc(); mem_rd = 1'b1; mem_wr = 1'b0; mem_addr = 32'h3C; dly_q.push_back(99);
    cyc(); cyc(); cyc();
    rst_n = 1'b0; mem_rd = 1'b0;
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_busReq", breq, 0);
    chk("mrst_busWe", bwe, 0);
    chk("mrst_busAddr", baddr, 0);
    chk("mrst_rdata", mem_rdata, 0);
    chk("mrst_err", err, 0);
    chk("mrst_stall", stall, 0);
    force_ack = 1'b1;
    cyc(); @(negedge clk);
    chk("late_ack_breq", breq, 0);
    force_ack = 1'b0;
    cyc(); @(negedge clk);
    chk("late_ack_breq2", breq, 0);
    chk("late_ack_err", err, 0);
    busy = 0;
    core_op(0, 32'h3C, 32'h0, 2, 0);

    // Misaligned read: no bus cycle, one-cycle error the cycle after
    r1 = req_cyc;
    core_op(0, 32'h13, 32'h0, 0, 0);
    chk("mis_err_now", err, 0);
    cyc(); mem_rd = 1'b0; mem_wr = 1'b0;
    @(negedge clk); chk("mis_err_pulse", err, 1);
    cyc(); @(negedge clk); chk("mis_err_end", err, 0);
    chk("mis_no_req", req_cyc - r1, 0);

    // Read timeout
    r1 = req_cyc;
    core_op(0, 32'h14, 32'h0, 99, 0);
    chk("tmo_err", err, 1);
    chk("tmo_breq_low", breq, 0);
    chk("tmo_req_cycles", req_cyc - r1, T);

    // Both strobes high
    r1 = req_cyc;
    core_op(2, 32'h18, 32'h5555_AAAA, 0, 0);
    cyc(); mem_rd = 1'b0; mem_wr = 1'b0;
    @(negedge clk); chk("both_err_pulse", err, 1);
    cyc(); @(negedge clk); chk("both_err_end", err, 0);
    chk("both_no_req", req_cyc - r1, 0);

    // Random traffic
    r0 = req_cyc - exp_req;
    e0 = err_cyc - exp_err;
    for (int i = 0; i < 80; i++) begin
      int k, d, g;
      logic [31:0] a;
      k   = $urandom_range(0, 3);
      idx = 6'($urandom_range(0, 15));
      a   = {24'h0, idx, 2'b00};
      d   = ($urandom_range(0, 7) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, T - 1);
      g   = $urandom_range(0, 3);
      if (k == 3) begin
        a = a | 32'($urandom_range(1, 3));
        k = $urandom_range(0, 1);
      end
      core_op(k, a, $urandom, d, g);
    end
    repeat (T + 6) begin cyc(); mem_rd = 1'b0; mem_wr = 1'b0; end
    @(negedge clk);
    chk("rand_req_cycles", req_cyc - r0, exp_req);
    chk("rand_err_cycles", err_cyc - e0, exp_err);
    for (int i = 0; i < 16; i++) chk("final_mem", bus_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory controller sitting directly downstream of the MIPS 5-stage core's MEM-stage port. It converts the core's single-cycle `memRead`/`memWrite` strobes into a registered request/acknowledge bus transaction with variable latency. Reads stall the core until data returns. Writes are posted into a one-entry buffer. Misaligned accesses and bus timeouts are flagged as errors.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width
- `TIMEOUT_CYCLES`, 255, maximum cycles `busReq__o` waits for `busAck__i` (range 1..65535)

Ports:
- `clock__i`  in  1  single clock; all state updates on the rising edge
- `reset_n__i`  in  1  reset, synchronous, active-low
- `memAddr__i`  in  ADDR_WIDTH  core data address
- `memDataWrite__i`  in  DATA_WIDTH  core store data
- `memRead__i`  in  1  core load strobe, held while stalled
- `memWrite__i`  in  1  core store strobe, held while stalled
- `memDataRead__o`  out  DATA_WIDTH  load data; valid when `memStall__o`=0 and `memRead__i`=1
- `memStall__o`  out  1  combinational; freezes the core pipeline
- `memError__o`  out  1  registered one-cycle error pulse
- `busReq__o`  out  1  registered bus request
- `busWe__o`  out  1  1 = write, 0 = read
- `busAddr__o`  out  ADDR_WIDTH  word-aligned bus address
- `busWData__o`  out  DATA_WIDTH  bus write data
- `busAck__i`  in  1  bus completion; sampled only while `busReq__o`=1
- `busRData__i`  in  DATA_WIDTH  read data, valid with `busAck__i`

## Operation
- **States:** IDLE, WR_BUS, RD_BUS, RD_DONE.
- **IDLE, read** (aligned, `memWrite__i`=0):
  - Register the address.
  - Next state RD_BUS.
  - `memStall__o`=1.
- **IDLE, write** (aligned, `memRead__i`=0):
  - Capture address and data into the write buffer.
  - Next state WR_BUS.
  - `memStall__o`=0 (posted write).
- **RD_BUS:**
  - `busReq__o`=1, `busWe__o`=0, address held stable.
  - On `busAck__i`: capture `busRData__i` and go to RD_DONE.
  - `memStall__o`=1.
- **RD_DONE:**
  - `memStall__o`=0 and `memDataRead__o` = captured data.
  - The core request present this cycle is the completing one; it is not re-issued.
  - Next state IDLE.
- **WR_BUS:**
  - `busReq__o`=1, `busWe__o`=1, buffered address and data.
  - On `busAck__i`: go to IDLE.
  - Any core read or write arriving in this state stalls until the buffer drains; it is accepted from IDLE on the following cycle.
- **No request** (`memRead__i`=`memWrite__i`=0): `memStall__o`=0.
- **Misaligned** (`memAddr__i[1:0]`≠0) **or both strobes high in IDLE:**
  - The access is dropped and no bus cycle is issued.
  - `memStall__o`=0.
  - `memError__o` pulses on the next cycle.
- **Timeout:**
  - A cycle counter runs in RD_BUS/WR_BUS.
  - If it reaches `TIMEOUT_CYCLES` with no ack: drop `busReq__o` and pulse `memError__o`.
  - A read goes to RD_DONE with data 0; a write goes to IDLE.
- `busAck__i` outside RD_BUS/WR_BUS is ignored.
- **Reset mid-transaction:**
  - State returns to IDLE, the write buffer is discarded, and the counter is cleared.
  - A late ack after reset is ignored.

## Timing
- **Reset values:** `busReq__o`=0, `busWe__o`=0, `busAddr__o`=0, `busWData__o`=0, `memDataRead__o`=0, `memError__o`=0, state IDLE.
- **Bus handshake:**
  - `busReq__o` rises the cycle after a request is accepted in IDLE.
  - Address and data stay stable until the ack is sampled.
  - `busReq__o` falls the cycle after the ack.
  - Back-to-back transactions leave at least one idle bus cycle.
- **Read latency:** with the ack in the first request cycle, the read completes in 3 cycles, each later ack cycle adding one: cycle 0 accepted, cycle 1 request+ack, cycle 2 RD_DONE with stall low.
- **Posted write:** costs the core 0 stall cycles when the buffer is empty.
- **Read after write:** a read following a pending write waits for the write ack, then takes the full read latency.
- **Counter:** counts from 1 in the first request cycle and resets on every state exit.

## Structure
- **Package `dmc_pkg`:**
  - `dmc_state_t` enum.
  - `READ_ERR_DATA` = 32'h0000_0000.
  - `ALIGN_MASK` = 2'b11.
- **Sub-module `M__TimeoutCounter`:**
  - Loadable up-counter with clear and terminal-count output, parameterised by width.
  - One instance.
- FSM, write buffer and read-data register live in the top module.

## Test plan
- **Read, ack in first cycle:** read at 0x0000_0010 with the bus returning 0x1234_5678 → stall high for cycles 0–1, low in cycle 2 with `memDataRead__o`=0x1234_5678; `busReq__o` high only in cycle 1.
- **Posted write then read:** write 0xCAFE_F00D to 0x20, then a read of 0x20 the next cycle with the ack delayed 4 cycles → write accepted with no stall; read stalls until the write ack, then issues its own request; returns the bus data.
- **Misaligned access:** read at 0x0000_0013 → no `busReq__o`, no stall, `memError__o` high for exactly 1 cycle, one cycle after the request.
- **Timeout:** `TIMEOUT_CYCLES`=8, read with no ack → `busReq__o` high 8 cycles then low; `memError__o` pulse; RD_DONE returns 0 with stall released.
- **Reset mid-read:**
  - Assert `reset_n__i`=0 for 1 cycle during RD_BUS → all outputs at reset values next cycle.
  - A late `busAck__i`=1 is ignored.
  - A new read then completes normally.
- **Both strobes high:** `memRead__i`=`memWrite__i`=1 → no bus cycle and a 1-cycle `memError__o`.
